// File: rtl/mix_columns_iter_if.sv
// Block-level handshake bundle for mix_columns_iter: input valid/ready with
// state and mode, output valid/ready with result, plus a busy indicator.
interface mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         inv_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  // Both sides use strict valid/ready semantics: a transfer happens on a rising
  // edge where valid and ready are both 1. valid, once raised, holds its payload
  // stable until that edge. ready may be asserted without valid.
  modport slave (
    input  in_valid, data_in, inv_mode, out_ready,
    output in_ready, out_valid, data_out, busy
  );

  modport master (
    output in_valid, data_in, inv_mode, out_ready,
    input  in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative AES (Inv)MixColumns engine, COLS_PER_CYCLE columns per clock.
// Define MIXCOL_FWD_EN to build the forward matrix as well as the inverse one.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  mix_columns_iter_if.slave  bus,
  output logic [1:0]         dbgState
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gBadCols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Column base of the final step: the step that touches column 3.
  localparam logic [1:0] LAST_BASE = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] COL_STEP  = 2'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, nextState;

  // Element 0 is column 0, i.e. bits [127:96] of the flat state.
  logic [0:3][31:0] work, nextWork;
  logic [127:0]     dataOut;
  logic [1:0]       colCnt;
  logic             lastStep;
  logic             useInv;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] invCol(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m2[4];
    logic [7:0] m4[4];
    logic [7:0] m8[4];
    logic [31:0] o;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xt(a[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
    end
    o = '0;
    // Row r coefficients {E,B,D,9} start at byte r and wrap.
    for (int r = 0; r < 4; r++) begin
      o[31-8*r -: 8] = (m8[r] ^ m4[r] ^ m2[r])
                     ^ (m8[(r+1)%4] ^ m2[(r+1)%4] ^ a[(r+1)%4])
                     ^ (m8[(r+2)%4] ^ m4[(r+2)%4] ^ a[(r+2)%4])
                     ^ (m8[(r+3)%4] ^ a[(r+3)%4]);
    end
    return o;
  endfunction

`ifdef MIXCOL_FWD_EN
  logic invLatched;

  function automatic logic [31:0] fwdCol(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m2[4];
    logic [31:0] o;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xt(a[i]);
    end
    o = '0;
    for (int r = 0; r < 4; r++) begin
      o[31-8*r -: 8] = m2[r] ^ (m2[(r+1)%4] ^ a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  assign useInv = invLatched;

  function automatic logic [31:0] mixCol(input logic [31:0] c, input logic inv);
    return inv ? invCol(c) : fwdCol(c);
  endfunction
`else
  // Decrypt-only build: the mode input is accepted but has no effect.
  logic unusedInvMode;
  assign unusedInvMode = bus.inv_mode;
  assign useInv        = 1'b1;

  function automatic logic [31:0] mixCol(input logic [31:0] c, input logic inv);
    logic [31:0] r;
    r = invCol(c);
    return inv ? r : r;
  endfunction
`endif

  assign lastStep = (colCnt == LAST_BASE);

  always_comb begin
    nextWork = work;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      nextWork[colCnt + 2'(k)] = mixCol(work[colCnt + 2'(k)], useInv);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.in_valid)  nextState = BUSY;
      BUSY:    if (lastStep)      nextState = DONE;
      DONE:    if (bus.out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work    <= '0;
      colCnt  <= '0;
      dataOut <= '0;
`ifdef MIXCOL_FWD_EN
      invLatched <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          work   <= bus.data_in;
          colCnt <= '0;
`ifdef MIXCOL_FWD_EN
          invLatched <= bus.inv_mode;
`endif
        end
        BUSY: begin
          work   <= nextWork;
          colCnt <= colCnt + COL_STEP;
          if (lastStep) dataOut <= nextWork;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == BUSY);
  assign bus.out_valid = (state == DONE);
  assign bus.data_out  = dataOut;
  assign dbgState      = state;

endmodule
